// File: rtl/cpu_pkg.sv
// Shared types and constants for the multi-cycle CPU control FSM.
// Optional JMP opcode is enabled by defining CPU_CTRL_JUMP_EN.
package cpu_pkg;

    localparam int unsigned OpMaxW = 6;
    typedef logic [OpMaxW-1:0] op_t;

    localparam op_t OpRtype = 6'd0;
    localparam op_t OpLw    = 6'd1;
    localparam op_t OpSw    = 6'd2;
    localparam op_t OpBeq   = 6'd3;
    localparam op_t OpAddi  = 6'd4;
`ifdef CPU_CTRL_JUMP_EN
    localparam op_t OpJmp   = 6'd5;
`endif

    typedef enum logic [2:0] {
        StIdle, StFetch, StDecode, StExec, StMem, StWb
    } state_e;

    typedef enum logic [1:0] {
        AluAdd   = 2'b00,
        AluSub   = 2'b01,
        AluFunct = 2'b10
    } alu_op_e;

    typedef struct packed {
        logic    mem_req;
        logic    reg_dst;
        logic    alu_src;
        logic    mem_to_reg;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    branch;
        logic    pc_write;
        logic    ir_write;
        logic    pc_src;
        alu_op_e alu_op;
    } ctrl_t;

    function automatic logic op_legal(input op_t op);
        case (op)
            OpRtype, OpLw, OpSw, OpBeq, OpAddi: return 1'b1;
`ifdef CPU_CTRL_JUMP_EN
            OpJmp:                              return 1'b1;
`endif
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Handshake and control bundle between the control FSM and the datapath/memory.
interface cpu_ctrl_fsm_if #(
    parameter int unsigned OPCODE_W = 4
);
    logic                en;
    logic [OPCODE_W-1:0] opcode;
    logic                zero;
    logic                mem_ready;
    logic                mem_req;
    logic                RegDst;
    logic                ALUSrc;
    logic                MemToReg;
    logic                RegWrite;
    logic                MemRead;
    logic                MemWrite;
    logic                Branch;
    logic                PCWrite;
    logic                IRWrite;
    logic                PCSrc;
    logic [1:0]          ALUOp;
    logic                instr_done;
    logic                illegal_op;
    logic                mem_timeout;

    modport slave (
        input  en, opcode, zero, mem_ready,
        output mem_req, RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch,
               PCWrite, IRWrite, PCSrc, ALUOp, instr_done, illegal_op, mem_timeout
    );

    modport master (
        output en, opcode, zero, mem_ready,
        input  mem_req, RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch,
               PCWrite, IRWrite, PCSrc, ALUOp, instr_done, illegal_op, mem_timeout
    );

endinterface

// File: rtl/cpu_ctrl_decode.sv
// Combinational control-word decode from FSM state and latched opcode.
// JMP decode present only when CPU_CTRL_JUMP_EN is defined.
module cpu_ctrl_decode
    import cpu_pkg::*;
(
    input  state_e state_i,
    input  op_t    op_i,
    input  logic   zero_i,
    input  logic   mem_ready_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            StFetch: begin
                ctrl_o.mem_req  = 1'b1;
                ctrl_o.mem_read = 1'b1;
                ctrl_o.ir_write = 1'b1;
                ctrl_o.pc_write = mem_ready_i;
            end
            StExec: begin
                case (op_i)
                    OpRtype: ctrl_o.alu_op = AluFunct;
                    OpLw, OpSw, OpAddi: begin
                        ctrl_o.alu_src = 1'b1;
                        ctrl_o.alu_op  = AluAdd;
                    end
                    OpBeq: begin
                        ctrl_o.alu_op   = AluSub;
                        ctrl_o.branch   = 1'b1;
                        ctrl_o.pc_src   = zero_i;
                        ctrl_o.pc_write = zero_i;
                    end
`ifdef CPU_CTRL_JUMP_EN
                    OpJmp: begin
                        ctrl_o.pc_src   = 1'b1;
                        ctrl_o.pc_write = 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
            StMem: begin
                ctrl_o.mem_req   = 1'b1;
                ctrl_o.mem_read  = (op_i == OpLw);
                ctrl_o.mem_write = (op_i == OpSw);
            end
            StWb: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = (op_i == OpRtype);
                ctrl_o.mem_to_reg = (op_i == OpLw);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle CPU control FSM: sequencing, memory wait timeout and status pulses.
// Define CPU_CTRL_JUMP_EN to accept opcode 5 as JMP.
module cpu_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter int unsigned OPCODE_W = 4,
    parameter int unsigned WAIT_MAX = 15
) (
    input logic           clk,
    input logic           rst,
    cpu_ctrl_fsm_if.slave bus
);

    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [7:0]          wait_q, wait_d;
    op_t                 op_ext;
    ctrl_t               ctrl;
    logic                mem_wait, timeout, finish, illegal;

    assign op_ext = OpMaxW'(op_q);

    cpu_ctrl_decode u_decode (
        .state_i     (state_q),
        .op_i        (op_ext),
        .zero_i      (bus.zero),
        .mem_ready_i (bus.mem_ready),
        .ctrl_o      (ctrl)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wait_d  = wait_q;
        timeout = 1'b0;
        finish  = 1'b0;
        illegal = 1'b0;

        // mem_ready excludes the cycle from counting, so a late ready beats the timeout
        mem_wait = ((state_q == StFetch) || (state_q == StMem)) && !bus.mem_ready;
        if (mem_wait) begin
            if (wait_q == 8'(WAIT_MAX - 1)) timeout = 1'b1;
            else                            wait_d  = wait_q + 8'd1;
        end

        unique case (state_q)
            StIdle: if (bus.en) state_d = StFetch;
            StFetch: begin
                if (bus.mem_ready) state_d = StDecode;
                else if (timeout)  state_d = StIdle;
            end
            StDecode: begin
                op_d = bus.opcode;
                if (op_legal(OpMaxW'(bus.opcode))) begin
                    state_d = StExec;
                end else begin
                    illegal = 1'b1;
                    finish  = 1'b1;
                end
            end
            StExec: begin
                if ((op_ext == OpLw) || (op_ext == OpSw))          state_d = StMem;
                else if ((op_ext == OpRtype) || (op_ext == OpAddi)) state_d = StWb;
                else                                                finish  = 1'b1;
            end
            StMem: begin
                if (bus.mem_ready) begin
                    if (op_ext == OpLw) state_d = StWb;
                    else                finish  = 1'b1;
                end else if (timeout) begin
                    state_d = StIdle;
                end
            end
            StWb:    finish  = 1'b1;
            default: state_d = StIdle;
        endcase

        if (finish) state_d = bus.en ? StFetch : StIdle;
        if (state_d != state_q) wait_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
        end
    end

    // Memory strobes are withdrawn in the timeout cycle itself
    assign bus.mem_req     = ctrl.mem_req & ~timeout;
    assign bus.MemRead     = ctrl.mem_read & ~timeout;
    assign bus.MemWrite    = ctrl.mem_write & ~timeout;
    assign bus.RegDst      = ctrl.reg_dst;
    assign bus.ALUSrc      = ctrl.alu_src;
    assign bus.MemToReg    = ctrl.mem_to_reg;
    assign bus.RegWrite    = ctrl.reg_write;
    assign bus.Branch      = ctrl.branch;
    assign bus.PCWrite     = ctrl.pc_write;
    assign bus.IRWrite     = ctrl.ir_write;
    assign bus.PCSrc       = ctrl.pc_src;
    assign bus.ALUOp       = ctrl.alu_op;
    assign bus.instr_done  = finish;
    assign bus.illegal_op  = illegal;
    assign bus.mem_timeout = timeout;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed table-driven bench for cpu_ctrl_fsm (OPCODE_W=4, WAIT_MAX=15).
module tb_cpu_ctrl_fsm;

    localparam logic [15:0] MREQ = 16'h8000, RDST = 16'h4000, ASRC = 16'h2000, M2R = 16'h1000;
    localparam logic [15:0] RWR  = 16'h0800, MRD  = 16'h0400, MWR  = 16'h0200, BR  = 16'h0100;
    localparam logic [15:0] PCW  = 16'h0080, IRW  = 16'h0040, PCS  = 16'h0020;
    localparam logic [15:0] AFN  = 16'h0010, ASUB = 16'h0008;
    localparam logic [15:0] DONE = 16'h0004, ILL  = 16'h0002, TMO = 16'h0001;
    localparam logic [15:0] FW   = MREQ | MRD | IRW;
    localparam logic [15:0] F    = FW | PCW;

    typedef struct {
        logic        en;
        logic [3:0]  op;
        logic        zero;
        logic        mr;
        logic [15:0] exp;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] outs;
    int          checks = 0;
    int          passed = 0;
    vec_t        vecs[$];

    cpu_ctrl_fsm_if #(.OPCODE_W(4)) bus ();

    cpu_ctrl_fsm #(
        .OPCODE_W (4),
        .WAIT_MAX (15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign outs = {bus.mem_req, bus.RegDst, bus.ALUSrc, bus.MemToReg, bus.RegWrite,
                   bus.MemRead, bus.MemWrite, bus.Branch, bus.PCWrite, bus.IRWrite,
                   bus.PCSrc, bus.ALUOp, bus.instr_done, bus.illegal_op, bus.mem_timeout};

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    endtask

    task automatic add(input logic en, input logic [3:0] op, input logic z, input logic mr,
                       input logic [15:0] e, input string n);
        vec_t v;
        v.en = en; v.op = op; v.zero = z; v.mr = mr; v.exp = e; v.name = n;
        vecs.push_back(v);
    endtask

    // Called 1 time unit after a rising edge; leaves 1 time unit after the next one.
    task automatic step(input logic en, input logic [3:0] op, input logic z, input logic mr,
                        input logic [15:0] e, input string n);
        bus.en = en; bus.opcode = op; bus.zero = z; bus.mem_ready = mr;
        #1;
        check(n, outs, e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.en = 1'b1; bus.opcode = '0; bus.zero = 1'b0; bus.mem_ready = 1'b1;

        add(1, 0, 0, 0, 0,                         "idle_start");
        add(1, 0, 0, 1, F,                         "rtype_fetch");
        add(1, 0, 0, 1, 0,                         "rtype_decode");
        add(1, 0, 0, 1, AFN,                       "rtype_exec");
        add(1, 0, 0, 1, RWR | RDST | DONE,         "rtype_wb");
        add(1, 0, 0, 1, F,                         "addi_fetch");
        add(1, 4, 0, 1, 0,                         "addi_decode");
        add(1, 0, 0, 1, ASRC,                      "addi_exec");
        add(1, 0, 0, 1, RWR | DONE,                "addi_wb");
        add(1, 0, 0, 1, F,                         "beq1_fetch");
        add(1, 3, 0, 1, 0,                         "beq1_decode");
        add(1, 0, 1, 1, BR | ASUB | PCS | PCW | DONE, "beq1_exec");
        add(1, 0, 0, 1, F,                         "beq0_fetch");
        add(1, 3, 0, 1, 0,                         "beq0_decode");
        add(1, 0, 0, 1, BR | ASUB | DONE,          "beq0_exec");
        add(1, 0, 0, 1, F,                         "sw_fetch");
        add(1, 2, 0, 1, 0,                         "sw_decode");
        add(1, 0, 0, 1, ASRC,                      "sw_exec");
        add(1, 0, 0, 1, MREQ | MWR | DONE,         "sw_mem");
        add(1, 0, 0, 0, FW,                        "lw_fetch_wait");
        add(1, 0, 0, 1, F,                         "lw_fetch");
        add(1, 1, 0, 1, 0,                         "lw_decode");
        add(1, 0, 0, 1, ASRC,                      "lw_exec");
        add(1, 0, 0, 0, MREQ | MRD,                "lw_mem_wait1");
        add(1, 0, 0, 0, MREQ | MRD,                "lw_mem_wait2");
        add(1, 0, 0, 0, MREQ | MRD,                "lw_mem_wait3");
        add(1, 0, 0, 1, MREQ | MRD,                "lw_mem_ready");
        add(1, 0, 0, 1, RWR | M2R | DONE,          "lw_wb");
        add(1, 0, 0, 1, F,                         "ill7_fetch");
        add(1, 7, 0, 1, ILL | DONE,                "ill7_decode");
        add(1, 0, 0, 1, F,                         "op5_fetch");
`ifdef CPU_CTRL_JUMP_EN
        add(1, 5, 0, 1, 0,                         "jmp_decode");
        add(1, 0, 0, 1, PCS | PCW | DONE,          "jmp_exec");
`else
        add(1, 5, 0, 1, ILL | DONE,                "op5_illegal");
`endif
        add(1, 0, 0, 1, F,                         "en_fetch");
        add(0, 0, 0, 1, 0,                         "en0_decode");
        add(0, 0, 0, 1, AFN,                       "en0_exec");
        add(0, 0, 0, 1, RWR | RDST | DONE,         "en0_wb");
        add(0, 0, 0, 1, 0,                         "idle_hold1");
        add(0, 0, 0, 1, 0,                         "idle_hold2");
        add(1, 0, 0, 1, 0,                         "idle_go");
        add(0, 0, 0, 1, F,                         "ill9_fetch");
        add(0, 9, 0, 1, ILL | DONE,                "ill9_decode");
        add(0, 0, 0, 1, 0,                         "idle_after_ill");

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", outs, 16'h0000);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].en, vecs[i].op, vecs[i].zero, vecs[i].mr, vecs[i].exp, vecs[i].name);

        // Fetch stalls until the wait limit trips
        step(1, 0, 0, 0, 0, "to_idle");
        for (int i = 0; i < 14; i++) step(1, 0, 0, 0, FW, "to_wait");
        bus.mem_ready = 1'b0;
        #1;
        check("timeout_pulse", 16'(outs[0]), 16'h0001);
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0, "idle_after_timeout");

        // Ready arriving on the last permitted cycle avoids the timeout
        for (int i = 0; i < 14; i++) step(1, 0, 0, 0, FW, "rw_wait");
        step(1, 0, 0, 1, F, "ready_wins");
        step(1, 2, 0, 1, 0, "rst_sw_decode");
        step(1, 0, 0, 1, ASRC, "rst_sw_exec");

        // Asynchronous reset in the middle of a stalled store
        bus.mem_ready = 1'b0;
        #1;
        check("sw_mem_stall", outs, MREQ | MWR);
        #1 rst = 1'b1;
        #1;
        check("rst_async", outs, 16'h0000);
        @(posedge clk);
        #1;
        check("rst_hold", outs, 16'h0000);
        rst = 1'b0;
        step(1, 0, 0, 1, 0, "idle_post_rst");
        step(1, 0, 0, 1, F, "fetch_post_rst");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
